// File: rtl/snake_mem_arbiter.sv
// Single-port arbiter for the snake tail memory: VGA renderer (read-only) has priority,
// the game side is guaranteed service after STARVE_LIMIT consecutive lost arbitrations.
module snake_mem_arbiter #(
    parameter int ADDR_W       = 6,
    parameter int DATA_W       = 12,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              game_req,
    input  logic              game_we,
    input  logic [ADDR_W-1:0] game_addr,
    input  logic [DATA_W-1:0] game_wdata,
    output logic              game_ack,
    output logic [DATA_W-1:0] game_rdata,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic              vga_ack,
    output logic [DATA_W-1:0] vga_rdata,
    output logic              mem_read_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        state_dbg,
    output logic [3:0]        starve_cnt_dbg
);

    // Handshake: each requester holds req (and its payload) high until it sees a one-cycle
    // ack; ack is issued in RESP, two cycles after the request is sampled in IDLE.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t     state, state_next;
    logic       owner_game;
    logic       acc_we;
    logic       start;
    logic       game_wins;
    logic [3:0] starve_cnt, starve_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        start       = 1'b0;
        game_wins   = 1'b0;
        starve_next = starve_cnt;
        case (state)
            IDLE: begin
                game_wins = game_req && (!vga_req || (starve_cnt == LIMIT));
                // An absent game request forgets any accumulated starvation.
                if (!game_req) begin
                    starve_next = 4'd0;
                end
                if (game_req || vga_req) begin
                    start      = 1'b1;
                    state_next = ACCESS;
                    if (game_wins) begin
                        starve_next = 4'd0;
                    end else if (game_req && (starve_cnt < LIMIT)) begin
                        starve_next = starve_cnt + 4'd1;
                    end
                end
            end
            ACCESS:  state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner_game <= 1'b0;
            acc_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            game_rdata <= '0;
            vga_rdata  <= '0;
            starve_cnt <= 4'd0;
        end else begin
            starve_cnt <= starve_next;
            if (start) begin
                owner_game <= game_wins;
                acc_we     <= game_wins && game_we;
                mem_addr   <= game_wins ? game_addr : vga_addr;
                if (game_wins) begin
                    mem_wdata <= game_wdata;
                end
            end
            // Read data lands in the owner's register at the end of ACCESS only.
            if ((state == ACCESS) && !acc_we) begin
                if (owner_game) begin
                    game_rdata <= mem_rdata;
                end else begin
                    vga_rdata <= mem_rdata;
                end
            end
        end
    end

    assign mem_read_write = (state == ACCESS) && owner_game && acc_we;
    assign game_ack       = (state == RESP) && owner_game;
    assign vga_ack        = (state == RESP) && !owner_game;
    assign state_dbg      = state;
    assign starve_cnt_dbg = starve_cnt;

endmodule

// File: tb/tb_snake_mem_arbiter.sv
// Bench for snake_mem_arbiter: behavioural tail memory, per-requester expected-data
// queues, grant-order log and latency/strobe checks.
module tb_snake_mem_arbiter;

    logic        clk;
    logic        reset;
    logic        game_req, game_we, game_ack;
    logic [5:0]  game_addr;
    logic [11:0] game_wdata, game_rdata;
    logic        vga_req, vga_ack;
    logic [5:0]  vga_addr;
    logic [11:0] vga_rdata;
    logic        mem_read_write;
    logic [5:0]  mem_addr;
    logic [11:0] mem_wdata, mem_rdata;
    logic [1:0]  state_dbg;
    logic [3:0]  starve_cnt_dbg;

    snake_mem_arbiter #(.ADDR_W(6), .DATA_W(12), .STARVE_LIMIT(4)) dut (
        .clk(clk), .reset(reset),
        .game_req(game_req), .game_we(game_we), .game_addr(game_addr),
        .game_wdata(game_wdata), .game_ack(game_ack), .game_rdata(game_rdata),
        .vga_req(vga_req), .vga_addr(vga_addr), .vga_ack(vga_ack), .vga_rdata(vga_rdata),
        .mem_read_write(mem_read_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .state_dbg(state_dbg), .starve_cnt_dbg(starve_cnt_dbg)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- memory environment ----------------
    logic [11:0] mem_array [64];
    logic [11:0] ref_mem   [64];
    int          strobe_cnt = 0;
    int          writes_issued = 0;

    assign mem_rdata = mem_array[mem_addr];

    always @(posedge clk) begin
        if (mem_read_write) begin
            mem_array[mem_addr] <= mem_wdata;
            strobe_cnt <= strobe_cnt + 1;
        end
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- scoreboard ----------------
    logic [11:0] game_exp_q[$];
    logic [11:0] vga_exp_q[$];
    logic        ack_log[$];
    logic [11:0] held_game = '0;
    logic [11:0] held_vga  = '0;
    logic [11:0] last_game_exp = '0;
    int          vga_ack_cnt = 0;

    always @(negedge clk) begin
        if (reset) begin
            held_game = '0;
            held_vga  = '0;
        end
        if (vga_ack) begin
            ack_log.push_back(1'b0);
            vga_ack_cnt++;
            if (vga_exp_q.size() == 0) check("vga_spurious_ack", 1, 0);
            else held_vga = vga_exp_q.pop_front();
        end
        if (game_ack) begin
            ack_log.push_back(1'b1);
            if (game_exp_q.size() == 0) check("game_spurious_ack", 1, 0);
            else held_game = game_exp_q.pop_front();
        end
        check("ack_onehot", {31'd0, vga_ack & game_ack}, 0);
        check("vga_rdata", {20'd0, vga_rdata}, {20'd0, held_vga});
        check("game_rdata", {20'd0, game_rdata}, {20'd0, held_game});
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic game_issue(input logic we, input logic [5:0] a, input logic [11:0] wd);
        game_we    = we;
        game_addr  = a;
        game_wdata = wd;
        game_req   = 1'b1;
        if (we) begin
            game_exp_q.push_back(last_game_exp);
            ref_mem[a] = wd;
            writes_issued++;
        end else begin
            last_game_exp = ref_mem[a];
            game_exp_q.push_back(last_game_exp);
        end
    endtask

    task automatic vga_issue(input logic [5:0] a);
        vga_addr = a;
        vga_req  = 1'b1;
        vga_exp_q.push_back(ref_mem[a]);
    endtask

    task automatic wait_game(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!game_ack && cyc < 64);
        if (!game_ack) check("game_ack_timeout", 0, 1);
        #1;
    endtask

    task automatic wait_vga(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!vga_ack && cyc < 64);
        if (!vga_ack) check("vga_ack_timeout", 0, 1);
        #1;
    endtask

    task automatic assert_reset();
        reset         = 1'b1;
        last_game_exp = '0;
        repeat (2) tick();
    endtask

    task automatic check_order(input logic [15:0] pattern, input int n);
        check("order_len", ack_log.size(), n);
        for (int i = 0; i < n; i++) begin
            if (i < ack_log.size()) check("grant_order", {31'd0, ack_log[i]}, {31'd0, pattern[i]});
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int cyc;
        int base_strobe;
        logic [11:0] v;
        reset = 1'b1;
        game_req = 0; game_we = 0; game_addr = 0; game_wdata = 0;
        vga_req = 0; vga_addr = 0;
        for (int i = 0; i < 64; i++) begin
            v = 12'($urandom_range(0, 4095));
            mem_array[i] = v;
            ref_mem[i]   = v;
        end
        mem_array[0] = 12'h123;
        ref_mem[0]   = 12'h123;

        // reset values
        @(negedge clk);
        check("rst_state", state_dbg, 0);
        check("rst_starve", starve_cnt_dbg, 0);
        check("rst_mem_rw", mem_read_write, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_game_ack", game_ack, 0);
        check("rst_vga_ack", vga_ack, 0);
        #1 reset = 1'b0;
        tick();

        // reset mid-ACCESS of a game write to addr 5
        game_issue(1'b1, 6'd5, 12'($urandom_range(0, 4095)));
        @(negedge clk);
        check("pre_rst_mem_rw", mem_read_write, 1);
        check("pre_rst_mem_addr", mem_addr, 5);
        #1 reset = 1'b1;
        #1;
        check("midrst_mem_rw", mem_read_write, 0);
        check("midrst_mem_addr", mem_addr, 0);
        check("midrst_mem_wdata", mem_wdata, 0);
        check("midrst_state", state_dbg, 0);
        check("midrst_game_ack", game_ack, 0);
        check("midrst_game_rdata", game_rdata, 0);
        repeat (2) tick();
        reset = 1'b0;
        wait_game(cyc);
        check("post_rst_latency", cyc, 2);
        check("post_rst_strobes", strobe_cnt, writes_issued);
        game_req = 1'b0;
        tick();

        // game write then read of addr 3
        base_strobe = strobe_cnt;
        game_issue(1'b1, 6'd3, 12'hA5C);
        wait_game(cyc);
        check("wr_latency", cyc, 2);
        check("wr_strobe_once", strobe_cnt - base_strobe, 1);
        game_req = 1'b0;
        tick();
        game_issue(1'b0, 6'd3, 12'h000);
        wait_game(cyc);
        check("rd_latency", cyc, 2);
        check("rd_value", game_rdata, 12'hA5C);
        check("rd_no_strobe", strobe_cnt - base_strobe, 1);
        game_req = 1'b0;
        tick();

        // single VGA read of addr 0
        base_strobe = strobe_cnt;
        vga_issue(6'd0);
        wait_vga(cyc);
        check("vga_latency", cyc, 2);
        check("vga_value", vga_rdata, 12'h123);
        check("vga_no_strobe", strobe_cnt - base_strobe, 0);
        vga_req = 1'b0;
        tick();

        // data isolation: VGA addr 7 then game addr 9
        vga_issue(6'd7);
        wait_vga(cyc);
        vga_req = 1'b0;
        tick();
        game_issue(1'b0, 6'd9, 12'h000);
        wait_game(cyc);
        check("iso_game", game_rdata, ref_mem[9]);
        check("iso_vga_kept", vga_rdata, ref_mem[7]);
        game_req = 1'b0;
        tick();

        // contention: both requests rise as reset deasserts
        assert_reset();
        ack_log.delete();
        base_strobe = strobe_cnt;
        reset = 1'b0;
        fork
            begin
                int c;
                for (int i = 0; i < 8; i++) begin
                    vga_issue(6'($urandom_range(0, 63)));
                    wait_vga(c);
                end
                vga_req = 1'b0;
            end
            begin
                int c;
                game_issue(1'b0, 6'($urandom_range(0, 63)), 12'h000);
                wait_game(c);
                check("contend_game_cycle", c, 14);
                game_issue(1'b0, 6'($urandom_range(0, 63)), 12'h000);
                wait_game(c);
                game_req = 1'b0;
            end
        join
        check_order(16'h0210, 10);
        check("contend_no_strobe", strobe_cnt - base_strobe, 0);
        tick();

        // game release clears starvation
        ack_log.delete();
        fork
            begin
                int c;
                for (int i = 0; i < 9; i++) begin
                    vga_issue(6'($urandom_range(0, 63)));
                    wait_vga(c);
                end
                vga_req = 1'b0;
            end
            begin
                int c;
                int target;
                int guard;
                target = vga_ack_cnt + 2;
                game_issue(1'b0, 6'($urandom_range(0, 63)), 12'h000);
                guard = 0;
                while (vga_ack_cnt < target && guard < 64) begin
                    tick();
                    guard++;
                end
                if (vga_ack_cnt < target) check("release_wait_timeout", 0, 1);
                check("starve_before_drop", starve_cnt_dbg, 2);
                game_req = 1'b0;
                tick();
                tick();
                game_req = 1'b1;
                check("starve_after_rerequest", starve_cnt_dbg, 0);
                wait_game(c);
                game_req = 1'b0;
            end
        join
        check_order(16'h0080, 10);
        tick();

        check("final_strobes", strobe_cnt, writes_issued);
        check("game_q_empty", game_exp_q.size(), 0);
        check("vga_q_empty", vga_exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/snake_mem_arbiter.md
# snake_mem_arbiter

Arbitrates single-port access to the snake tail memory between two requesters: the game logic (read/write) and the VGA renderer (read-only). It sits between both requesters and `snake_memory`, driving that memory's read/write strobe, address and write data. It serialises all accesses through a three-state FSM, gives the VGA side priority, and guarantees the game side bounded wait via a starvation counter.

## Interface

Parameters:
- `ADDR_W`, default 6: tail address width (tail index).
- `DATA_W`, default 12: tail position word width.
- `STARVE_LIMIT`, default 4: number of lost arbitrations after which game wins the next one; range 1..15.

Ports:
- `clk` input 1: single clock; all state changes on rising edge.
- `reset` input 1: asynchronous, active-high; clears all state immediately.
- `game_req` input 1: game access request; level, held until `game_ack`.
- `game_we` input 1: 1 = write, 0 = read; stable while `game_req` high.
- `game_addr` input ADDR_W: game tail address; stable while `game_req` high.
- `game_wdata` input DATA_W: game write data; stable while `game_req` high.
- `game_ack` output 1: one-cycle completion pulse.
- `game_rdata` output DATA_W: read data; valid when `game_ack`=1, held until next game read completes.
- `vga_req` input 1: VGA read request; level, held until `vga_ack`.
- `vga_addr` input ADDR_W: VGA tail address; stable while `vga_req` high.
- `vga_ack` output 1: one-cycle completion pulse.
- `vga_rdata` output DATA_W: read data; valid when `vga_ack`=1, held until next VGA completion.
- `mem_read_write` output 1: memory write strobe, 1 = write.
- `mem_addr` output ADDR_W: memory address.
- `mem_wdata` output DATA_W: memory write data.
- `mem_rdata` input DATA_W: memory read data; combinational from `mem_addr`.

## Operation

- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If no request is pending, stay in IDLE.
  - Otherwise arbitrate, then register owner, address, write enable and write data, and go to ACCESS.
- Arbitration:
  - Only `vga_req`: VGA wins.
  - Only `game_req`: game wins.
  - Both requests: VGA wins unless `starve_cnt` == STARVE_LIMIT, in which case game wins.
- ACCESS:
  - `mem_addr` and `mem_wdata` are driven from the registered values.
  - `mem_read_write`=1 only for a game write, and only in this state.
  - At the end of the cycle, `mem_rdata` is captured into the owner's rdata register (reads only; writes leave rdata unchanged).
  - Next state: RESP.
- RESP: the owner's ack is 1 for exactly this cycle; next state is IDLE. The requester drops or changes its request in the cycle after ack.
- `starve_cnt` (4 bits) is updated at each IDLE→ACCESS transition:
  - +1 if `game_req`=1 and VGA won.
  - Cleared to 0 if game won.
  - Cleared to 0 whenever `game_req`=0 in IDLE.
  - Saturates at STARVE_LIMIT.
- VGA never writes: `mem_read_write` is never 1 for a VGA-owned access.
- Outside ACCESS, `mem_addr` and `mem_wdata` hold their last values and `mem_read_write`=0.

## Timing

- Reset values: state IDLE, `game_ack`=0, `vga_ack`=0, `game_rdata`=0, `vga_rdata`=0, `mem_read_write`=0, `mem_addr`=0, `mem_wdata`=0, `starve_cnt`=0.
- Latency: a request seen in IDLE at edge N is driven to memory in cycle N+1 (ACCESS), and ack occurs in cycle N+2 (RESP).
- Throughput: one access per 3 cycles; back-to-back requests alternate per the priority rule.
- Reset asserted mid-ACCESS: `mem_read_write` drops to 0 immediately (asynchronous), no ack is issued, and the requester must keep `req` high to be re-served after reset.
- A request withdrawn before ack: behaviour is undefined; requesters must not do this.
- Both reqs rise in the same cycle as reset deassertion: VGA is served first (`starve_cnt`=0).

## Test plan

- Reset: drive `reset`=1 mid-ACCESS of a game write to addr 5 → `mem_read_write`=0 within the same cycle, all outputs at reset values, no ack.
- Single game write then read: write addr 3 data 12'hA5C, then read addr 3 → `mem_read_write`=1 for exactly one cycle, each ack arrives 2 cycles after the request is seen, `game_rdata`=12'hA5C.
- Single VGA read: VGA reads addr 0 with memory holding 12'h123 → `vga_ack` 2 cycles after the request, `vga_rdata`=12'h123, `mem_read_write` stays 0.
- Contention: both reqs held continuously with STARVE_LIMIT=4 → grant order V,V,V,V,G,V,V,V,V,G; the game ack arrives at the 5th access (cycle 14 after the first IDLE).
- Game release clears starvation: game loses 2 arbitrations, drops `game_req` for 1 IDLE cycle, then re-requests → `starve_cnt` restarts at 0 and VGA wins the next 4 arbitrations.
- Data isolation: a VGA read of addr 7 followed by a game read of addr 9 → `game_rdata` changes only on `game_ack`, and `vga_rdata` keeps the addr 7 value.
